// File: rtl/dot_product_stream.sv
`default_nettype none
// =============================================================================
// Module     : dot_product_stream
// Description: Multi-lane streaming dot-product engine with runtime vector
//              length, signed/unsigned modes and valid/ready backpressure.
//              Optional macro DOTP_SATURATE_EN clamps the result to OUT_WIDTH.
// Revision   : 1.0 - initial release
// =============================================================================
module dot_product_stream #(
   parameter  int DATA_WIDTH = 8,
   parameter  int LANES      = 2,
   parameter  int MAX_BEATS  = 8,
   parameter  int OUT_WIDTH  = 16,
   localparam int LEN_W      = $clog2(MAX_BEATS + 1),
   localparam int ACC_W      = 2 * DATA_WIDTH + $clog2(LANES * MAX_BEATS) + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [LEN_W-1:0]              cfg_len,
   input  logic                          cfg_signed,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]   in_a,
   input  logic [LANES*DATA_WIDTH-1:0]   in_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          out_result,
   output logic                          out_sat,
   output logic                          busy
);

   logic                    w_en;
   logic                    w_accept;
   logic [LEN_W-1:0]        w_len_eff;
   logic [LEN_W-1:0]        w_cur_len;
   logic                    w_cur_sgn;
   logic                    w_first;
   logic                    w_last;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [LEN_W-1:0]        len_q;
   logic                    sgn_q;

   logic signed [ACC_W-1:0] w_prod [LANES];
   logic                    s1_valid_q, s1_first_q, s1_last_q, s1_sgn_q;
   logic signed [ACC_W-1:0] s1_prod_q [LANES];

   logic signed [ACC_W-1:0] w_lane_sum;
   logic                    s2_valid_q, s2_first_q, s2_last_q, s2_sgn_q;
   logic signed [ACC_W-1:0] s2_sum_q;

   logic signed [ACC_W-1:0] w_acc_sum;
   logic signed [ACC_W-1:0] acc_q;
   logic                    s3_valid_q, s3_sgn_q;
   logic signed [ACC_W-1:0] s3_total_q;

   logic [OUT_WIDTH-1:0]    w_res;
   logic                    w_sat;
   logic                    out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]    out_result_q, out_result_d;
   logic                    out_sat_q, out_sat_d;

   // The whole pipe freezes only while a result is held unaccepted.
   assign w_en     = !(out_valid_q && !out_ready);
   assign w_accept = in_valid && w_en;
   assign in_ready = w_en;

   always_comb begin
      if (cfg_len == '0)
         w_len_eff = LEN_W'(1);
      else if (cfg_len > LEN_W'(MAX_BEATS))
         w_len_eff = LEN_W'(MAX_BEATS);
      else
         w_len_eff = cfg_len;
   end

   // The opening beat uses live configuration; later beats use the latched copy.
   assign w_first   = (cnt_q == '0);
   assign w_cur_len = w_first ? w_len_eff  : len_q;
   assign w_cur_sgn = w_first ? cfg_signed : sgn_q;
   assign w_last    = (cnt_q == (w_cur_len - LEN_W'(1)));
   assign cnt_d     = w_last ? '0 : (cnt_q + LEN_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         len_q <= '0;
         sgn_q <= 1'b0;
      end else if (w_accept) begin
         cnt_q <= cnt_d;
         if (w_first) begin
            len_q <= w_len_eff;
            sgn_q <= cfg_signed;
         end
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic        [DATA_WIDTH-1:0] w_a, w_b;
         logic signed [ACC_W-1:0]      w_ea, w_eb;
         assign w_a       = in_a[i*DATA_WIDTH +: DATA_WIDTH];
         assign w_b       = in_b[i*DATA_WIDTH +: DATA_WIDTH];
         assign w_ea      = w_cur_sgn ? ACC_W'($signed(w_a)) : ACC_W'(w_a);
         assign w_eb      = w_cur_sgn ? ACC_W'($signed(w_b)) : ACC_W'(w_b);
         assign w_prod[i] = w_ea * w_eb;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sgn_q   <= 1'b0;
         for (int i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
      end else if (w_en) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_first_q <= w_first;
            s1_last_q  <= w_last;
            s1_sgn_q   <= w_cur_sgn;
            for (int i = 0; i < LANES; i++) s1_prod_q[i] <= w_prod[i];
         end
      end
   end

   always_comb begin
      w_lane_sum = '0;
      for (int i = 0; i < LANES; i++) w_lane_sum = w_lane_sum + s1_prod_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_sgn_q   <= 1'b0;
         s2_sum_q   <= '0;
      end else if (w_en) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_sgn_q   <= s1_sgn_q;
            s2_sum_q   <= w_lane_sum;
         end
      end
   end

   assign w_acc_sum = s2_first_q ? s2_sum_q : (acc_q + s2_sum_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         s3_valid_q <= 1'b0;
         s3_sgn_q   <= 1'b0;
         s3_total_q <= '0;
      end else if (w_en) begin
         s3_valid_q <= s2_valid_q && s2_last_q;
         if (s2_valid_q) begin
            acc_q <= w_acc_sum;
            if (s2_last_q) begin
               s3_total_q <= w_acc_sum;
               s3_sgn_q   <= s2_sgn_q;
            end
         end
      end
   end

`ifdef DOTP_SATURATE_EN
   localparam int EXT_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
   localparam logic signed [EXT_W-1:0] SMAX =
      {{(EXT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SMIN =
      {{(EXT_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
   localparam logic signed [EXT_W-1:0] UMAX =
      {{(EXT_W - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   logic signed [EXT_W-1:0] w_tot_ext;
   assign w_tot_ext = EXT_W'(s3_total_q);

   always_comb begin
      w_res = OUT_WIDTH'(w_tot_ext);
      w_sat = 1'b0;
      if (s3_sgn_q) begin
         if (w_tot_ext > SMAX) begin
            w_res = SMAX[OUT_WIDTH-1:0];
            w_sat = 1'b1;
         end else if (w_tot_ext < SMIN) begin
            w_res = SMIN[OUT_WIDTH-1:0];
            w_sat = 1'b1;
         end
      end else begin
         if (w_tot_ext[EXT_W-1]) begin
            w_res = '0;
            w_sat = 1'b1;
         end else if (w_tot_ext > UMAX) begin
            w_res = '1;
            w_sat = 1'b1;
         end
      end
   end
`else
   assign w_res = s3_sgn_q ? OUT_WIDTH'(s3_total_q) : OUT_WIDTH'($unsigned(s3_total_q));
   assign w_sat = 1'b0;
`endif

   // A result arriving in the handshake cycle replaces the old one, keeping valid high.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_sat_d    = out_sat_q;
      if (w_en && s3_valid_q) begin
         out_valid_d  = 1'b1;
         out_result_d = w_res;
         out_sat_d    = w_sat;
      end else if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_sat_q    <= out_sat_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_sat    = out_sat_q;
   assign busy       = (cnt_q != '0) || s1_valid_q || s2_valid_q || s3_valid_q;

endmodule
`default_nettype wire
